// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package display_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Width of a counter that spans 0..scan_div-1, never narrower than one bit.
  function automatic int slot_cnt_width(input int scan_div);
    return (scan_div > 1) ? $clog2(scan_div) : 1;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Free-running digit-slot counter: flags the last blanking cycle and the last slot cycle.
module scan_slot_timer
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic [slot_cnt_width(SCAN_DIV)-1:0]   o_slot_cnt,
  output logic                                  o_blank_done,
  output logic                                  o_slot_done
);

  localparam int CW = slot_cnt_width(SCAN_DIV);

  logic [CW-1:0] r_slot_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt <= '0;
    end else if (o_slot_done) begin
      r_slot_cnt <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  assign o_slot_cnt   = r_slot_cnt;
  assign o_blank_done = (r_slot_cnt == CW'(BLANK_CYCLES - 1));
  assign o_slot_done  = (r_slot_cnt == CW'(SCAN_DIV - 1));

endmodule

// File: rtl/hex_digit_scanner.sv
// Multiplexed common-anode display scanner with tear-free frame updates and
// optional leading-zero suppression; all outputs are registered.
module hex_digit_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic                      load,
  input  logic                      lz_en,
  output logic [3:0]                hex_out,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = slot_cnt_width(SCAN_DIV);
  localparam int VW = 4 * NUM_DIGITS;

  scan_state_t     r_state;
  logic [IW-1:0]   r_digit_idx;
  logic [VW-1:0]   r_shadow;
  logic [VW-1:0]   r_display;
  logic            r_pending;

  logic [CW-1:0]   w_slot_cnt;
  logic            w_blank_done;
  logic            w_slot_done;

  scan_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .o_slot_cnt   (w_slot_cnt),
    .o_blank_done (w_blank_done),
    .o_slot_done  (w_slot_done)
  );

  logic                  w_last_digit;
  logic                  w_boundary;
  logic [IW-1:0]         w_idx_next;
  logic [VW-1:0]         w_display_next;
  logic                  w_drive_next;
  logic                  w_tick_next;
  logic                  w_suppressed;
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic [NUM_DIGITS-1:0] w_en_next;
  logic [3:0]            w_nibbles [NUM_DIGITS];

  assign w_last_digit = (r_digit_idx == IW'(NUM_DIGITS - 1));
  assign w_boundary   = w_slot_done && w_last_digit;

  assign w_idx_next = !w_slot_done ? r_digit_idx :
                      (w_last_digit ? '0 : r_digit_idx + 1'b1);

  // A load landing on the boundary cycle bypasses shadow so it is not lost a frame.
  assign w_display_next = !w_boundary ? r_display :
                          (load      ? value_in :
                          (r_pending ? r_shadow : r_display));

  assign w_drive_next = (r_state == BLANK) ? w_blank_done : !w_slot_done;
  assign w_tick_next  = w_last_digit && (w_slot_cnt == CW'(SCAN_DIV - 2));

  // Outputs are registered, so everything is evaluated for the upcoming cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nibbles[gi]    = w_display_next[4*gi +: 4];
      assign w_upper_zero[gi] = (w_display_next[VW-1:4*gi] == '0);
    end
  endgenerate

  assign w_suppressed = lz_en && (w_idx_next != '0) && w_upper_zero[w_idx_next];
  assign w_en_next    = (w_drive_next && !w_suppressed) ?
                        ~(NUM_DIGITS'(1) << w_idx_next) : '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BLANK;
      r_digit_idx <= '0;
      r_shadow    <= '0;
      r_display   <= '0;
      r_pending   <= 1'b0;
      hex_out     <= 4'h0;
      digit_en    <= '1;
      frame_tick  <= 1'b0;
    end else begin
      case (r_state)
        BLANK:   if (w_blank_done) r_state <= DRIVE;
        DRIVE:   if (w_slot_done)  r_state <= BLANK;
        default: r_state <= BLANK;
      endcase

      r_digit_idx <= w_idx_next;
      r_display   <= w_display_next;

      if (load) begin
        r_shadow <= value_in;
      end

      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end

      hex_out    <= w_nibbles[w_idx_next];
      digit_en   <= w_en_next;
      frame_tick <= w_tick_next;
    end
  end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with a frame-level reference model
// checked every cycle, plus literal spot checks.
module tb_hex_digit_scanner;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  hex_out;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  hex_digit_scanner #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .lz_en      (lz_en),
    .hex_out    (hex_out),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
    end
  endtask

  // Expected values from the display rules: slot position decides blanking,
  // the frame's shown value decides nibble and suppression.
  function automatic logic [3:0] model_en(input int t, input logic [15:0] v, input logic lz);
    int d;
    int ph;
    logic [3:0] onehot;
    d = (t % FR) / SD;
    ph = t % SD;
    onehot = 4'b0001;
    if (ph < BC) return 4'hF;
    if (lz && d > 0 && (v >> (4 * d)) == 16'h0) return 4'hF;
    return ~(onehot << d);
  endfunction

  function automatic logic [3:0] model_hex(input int t, input logic [15:0] v);
    int d;
    d = (t % FR) / SD;
    return 4'((v >> (4 * d)) & 16'hF);
  endfunction

  int          m_t = 0;
  logic [15:0] m_shown = 16'h0;
  logic [15:0] m_latest = 16'h0;
  logic        m_has = 1'b0;
  logic        m_lz = 1'b0;
  logic        m_rst_prev = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (m_rst_prev && rst) begin
        chk("rst_hex", m_t, 16'(hex_out), 16'h0);
        chk("rst_en", m_t, 16'(digit_en), 16'hF);
        chk("rst_tick", m_t, 16'(frame_tick), 16'h0);
      end else begin
        chk("hex", m_t, 16'(hex_out), 16'(model_hex(m_t, m_shown)));
        chk("en", m_t, 16'(digit_en), 16'(model_en(m_t, m_shown, m_lz)));
        chk("tick", m_t, 16'(frame_tick), 16'((m_t % FR) == FR - 1));
      end
      if (rst) begin
        m_t = 0;
        m_shown = 16'h0;
        m_has = 1'b0;
      end else begin
        if (load) begin
          m_latest = value_in;
          m_has = 1'b1;
        end
        if ((m_t % FR) == FR - 1 && m_has) begin
          m_shown = m_latest;
          m_has = 1'b0;
        end
        m_t++;
      end
      m_lz = lz_en;
      m_rst_prev = rst;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_load(input int c, input logic [15:0] v);
    run_to(c);
    load = 1'b1;
    value_in = v;
    step();
    load = 1'b0;
  endtask

  task automatic at_neg(input int c);
    run_to(c);
    @(negedge clk);
  endtask

  initial begin
    // Free-running scan after reset
    do_reset();
    at_neg(0);  chk("A_en0", cyc, 16'(digit_en), 16'hF);
    at_neg(2);  chk("A_en2", cyc, 16'(digit_en), 16'hE);
    at_neg(10); chk("A_en10", cyc, 16'(digit_en), 16'hD);
    at_neg(17); chk("A_en17", cyc, 16'(digit_en), 16'hF);
    at_neg(23); chk("A_en23", cyc, 16'(digit_en), 16'hB);
    at_neg(26); chk("A_en26", cyc, 16'(digit_en), 16'h7);
    at_neg(30); chk("A_tick30", cyc, 16'(frame_tick), 16'h0);
    at_neg(31); chk("A_tick31", cyc, 16'(frame_tick), 16'h1);
    at_neg(63); chk("A_tick63", cyc, 16'(frame_tick), 16'h1);

    // Single load mid-frame
    do_reset();
    pulse_load(5, 16'h1A2F);
    at_neg(31); chk("B_hex31", cyc, 16'(hex_out), 16'h0);
    at_neg(32); chk("B_hex32", cyc, 16'(hex_out), 16'hF);
    at_neg(42); chk("B_hex42", cyc, 16'(hex_out), 16'h2);
    at_neg(50); chk("B_hex50", cyc, 16'(hex_out), 16'hA);
    at_neg(58); chk("B_hex58", cyc, 16'(hex_out), 16'h1);
    run_to(64);

    // Last load in a frame wins
    do_reset();
    pulse_load(10, 16'h1111);
    pulse_load(20, 16'h2222);
    at_neg(34); chk("C_hex34", cyc, 16'(hex_out), 16'h2);
    at_neg(44); chk("C_hex44", cyc, 16'(hex_out), 16'h2);
    run_to(64);

    // Load on the frame_tick cycle
    do_reset();
    pulse_load(31, 16'h00C0);
    at_neg(38); chk("D_hex38", cyc, 16'(hex_out), 16'h0);
    at_neg(40); chk("D_hex40", cyc, 16'(hex_out), 16'hC);
    at_neg(42); chk("D_en42", cyc, 16'(digit_en), 16'hD);
    run_to(64);

    // Leading-zero suppression
    do_reset();
    lz_en = 1'b1;
    pulse_load(3, 16'h0050);
    at_neg(34); chk("E_en34", cyc, 16'(digit_en), 16'hE);
    chk("E_hex34", cyc, 16'(hex_out), 16'h0);
    at_neg(42); chk("E_en42", cyc, 16'(digit_en), 16'hD);
    chk("E_hex42", cyc, 16'(hex_out), 16'h5);
    at_neg(50); chk("E_en50", cyc, 16'(digit_en), 16'hF);
    at_neg(58); chk("E_en58", cyc, 16'(digit_en), 16'hF);
    pulse_load(60, 16'h0000);
    at_neg(66); chk("E_en66", cyc, 16'(digit_en), 16'hE);
    chk("E_hex66", cyc, 16'(hex_out), 16'h0);
    at_neg(74); chk("E_en74", cyc, 16'(digit_en), 16'hF);
    run_to(96);
    lz_en = 1'b0;

    // Reset mid-frame discards a pending load
    do_reset();
    pulse_load(8, 16'hBEEF);
    run_to(13);
    do_reset();
    at_neg(2);  chk("F_en2", cyc, 16'(digit_en), 16'hE);
    at_neg(32); chk("F_hex32", cyc, 16'(hex_out), 16'h0);
    at_neg(42); chk("F_hex42", cyc, 16'(hex_out), 16'h0);
    run_to(64);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
